// File: rtl/io_bitbang_pkg.sv
// Shared opcodes, sequencer state encoding and default pin count for io_bitbang_seq.
// Optional 2-flop pin synchronizer is selected with IO_BITBANG_SEQ_SYNC_EN.
package io_bitbang_pkg;

  localparam int IO_NUM_DEFAULT = 10;

  localparam logic [1:0] OP_DIR    = 2'd0;
  localparam logic [1:0] OP_OUT    = 2'd1;
  localparam logic [1:0] OP_SAMPLE = 2'd2;
  localparam logic [1:0] OP_WAIT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/io_sync2.sv
// Parameterized-width 2-flop synchronizer, synchronous active-low reset to 0.
// Only built when IO_BITBANG_SEQ_SYNC_EN is defined, since that is its only user.
`ifdef IO_BITBANG_SEQ_SYNC_EN
module io_sync2 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`endif

// File: rtl/io_bitbang_seq.sv
// Command sequencer owning io_bitbang direction/outval: masked writes, pin samples, timed waits.
// Macro IO_BITBANG_SEQ_SYNC_EN inserts a 2-flop synchronizer on the sampled pins.
module io_bitbang_seq
  import io_bitbang_pkg::*;
#(
  parameter int IO_NUM_OF = IO_NUM_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IO_NUM_OF-1:0] cmd_mask,
  input  logic [IO_NUM_OF-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IO_NUM_OF-1:0] rsp_data,
  output logic [IO_NUM_OF-1:0] out_io_direction,
  output logic [IO_NUM_OF-1:0] out_io_outval,
  input  logic [IO_NUM_OF-1:0] in_io_pins
);

  localparam logic [IO_NUM_OF-1:0] CNT_LAST = {{(IO_NUM_OF-1){1'b0}}, 1'b1};

  seq_state_t           r_state;
  logic                 r_rdy_en;
  logic [IO_NUM_OF-1:0] r_dir;
  logic [IO_NUM_OF-1:0] r_outv;
  logic                 r_rsp_vld;
  logic [IO_NUM_OF-1:0] r_rsp_dat;
  logic [IO_NUM_OF-1:0] r_cnt;
  logic [IO_NUM_OF-1:0] w_sample;
  logic                 w_cmd_fire;

`ifdef IO_BITBANG_SEQ_SYNC_EN
  io_sync2 #(.WIDTH(IO_NUM_OF)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (in_io_pins),
    .o_q   (w_sample)
  );
`else
  assign w_sample = in_io_pins;
`endif

  // r_rdy_en keeps cmd_ready low through reset and for the reset edge itself.
  assign cmd_ready  = (r_state == ST_IDLE) && r_rdy_en;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rdy_en  <= 1'b0;
      r_dir     <= '0;
      r_outv    <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_cnt     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            case (cmd_op)
              OP_DIR: r_dir  <= (r_dir  & ~cmd_mask) | (cmd_data & cmd_mask);
              OP_OUT: r_outv <= (r_outv & ~cmd_mask) | (cmd_data & cmd_mask);
              OP_SAMPLE: begin
                r_rsp_dat <= w_sample;
                r_rsp_vld <= 1'b1;
                r_state   <= ST_RESP;
              end
              default: begin
                if (cmd_data != '0) begin
                  r_cnt   <= cmd_data;
                  r_state <= ST_WAIT;
                end
              end
            endcase
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_LAST;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid        = r_rsp_vld;
  assign rsp_data         = r_rsp_dat;
  assign out_io_direction = r_dir;
  assign out_io_outval    = r_outv;

endmodule

// File: doc/io_bitbang_seq.md
# io_bitbang_seq

Command-driven sequencer that sits directly upstream of `io_bitbang` and owns its `in_io_direction` / `in_io_outval` registers. A host issues masked direction writes, masked output writes, pin samples and timed waits over a valid/ready command channel. Sampled pin values return on a valid/ready response channel. The `io_pins` bus that `io_bitbang` drives is fed back here as the sample input.

## Interface
- `IO_NUM_OF`, default 10: number of pins. Sets the width of every data, mask and pin bus.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_op` input 2: opcode. 0 = DIR, 1 = OUT, 2 = SAMPLE, 3 = WAIT.
- `cmd_mask` input `IO_NUM_OF`: per-bit write enable for DIR and OUT. Ignored for SAMPLE and WAIT.
- `cmd_data` input `IO_NUM_OF`: write value for DIR/OUT, or unsigned cycle count for WAIT.
- `rsp_valid` output 1: sample result available.
- `rsp_ready` input 1: host takes the result.
- `rsp_data` output `IO_NUM_OF`: sampled pin value.
- `out_io_direction` output `IO_NUM_OF`: drives `io_bitbang.in_io_direction`. 1 = pin driven.
- `out_io_outval` output `IO_NUM_OF`: drives `io_bitbang.in_io_outval`.
- `in_io_pins` input `IO_NUM_OF`: resolved pad values from `io_pins`.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- States are IDLE, WAIT and RESP. Reset forces IDLE.
- In IDLE, `cmd_ready` = 1. In WAIT and RESP, `cmd_ready` = 0.
- DIR: `out_io_direction <= (out_io_direction & ~cmd_mask) | (cmd_data & cmd_mask)`. State stays IDLE.
- OUT: the same masked update, applied to `out_io_outval`. State stays IDLE.
- SAMPLE: `rsp_data <= sampled pins` and `rsp_valid <= 1`, then go to RESP. RESP returns to IDLE on the edge where `rsp_valid && rsp_ready`.
- WAIT with count K > 0: load the counter with K, then go to WAIT. The counter decrements each cycle, and the block returns to IDLE on the edge where the counter reaches 1.
- WAIT with K = 0: no-op, stays IDLE.
- `rsp_data` is held stable while `rsp_valid` = 1.
- Masked-off bits keep their value.
- Reset values:
  - `out_io_direction` = 0 (all pins released)
  - `out_io_outval` = 0
  - `rsp_valid` = 0
  - `rsp_data` = 0
  - counter = 0
  - `cmd_ready` = 0 during reset, 1 from the first cycle after `rst_n` rises.
- Reset mid-operation: any pending WAIT or unread response is discarded, and all pins are released on the same edge.

## Timing
- DIR/OUT:
  - Result is visible on the outputs in the cycle after the accept edge.
  - Throughput is one command per cycle with `cmd_ready` held at 1.
  - Back-to-back writes to the same register compose in order.
- SAMPLE:
  - `rsp_valid` rises in the cycle after the accept edge.
  - The captured value is the sample-path output at the accept edge.
  - If `rsp_ready` is high in that first cycle, `cmd_ready` returns to 1 in the next cycle. This is the minimum 2-cycle command period.
- WAIT K:
  - `cmd_ready` is low for exactly K cycles following the accept cycle.
  - The maximum K is 2^`IO_NUM_OF` − 1.
- A pin change reaches `in_io_pins` through `io_bitbang` combinationally. The sample-path latency is set by Configuration.
- `cmd_*` inputs are ignored when `cmd_ready` = 0.

## Configuration
- `IO_BITBANG_SEQ_SYNC_EN` defined:
  - `in_io_pins` passes through a 2-flop synchronizer before sampling.
  - A pin change is visible to SAMPLE 2 cycles later.
  - The synchronizer flops reset to 0.
- Undefined: SAMPLE captures `in_io_pins` directly, with zero added latency.

## Structure
- Package `io_bitbang_pkg` holds:
  - opcode constants `OP_DIR`, `OP_OUT`, `OP_SAMPLE`, `OP_WAIT`
  - state enum `seq_state_t`
  - default width `IO_NUM_DEFAULT` = 10
- Sub-module `io_sync2`: parameterized-width 2-flop synchronizer with synchronous active-low reset. It is instantiated only when `IO_BITBANG_SEQ_SYNC_EN` is defined.

## Test plan
All scenarios use `IO_NUM_OF` = 10, with the bench's pad model driving the inverse-direction pins.
- Reset release: `out_io_direction` = 0x000, `out_io_outval` = 0x000, `rsp_valid` = 0, and `cmd_ready` = 1 one cycle after `rst_n` rises.
- Writes, back to back:
  - DIR mask 0x3FF data 0x3FF, then OUT mask 0x3FF data 0x2AA, then OUT mask 0x00F data 0x155.
  - Required: direction 0x3FF, then outval 0x2AA, then outval 0x2A5, on consecutive cycles.
- Sample driven pins: DIR 0x255, OUT 0x3FF, pad model drives 0x3A5 on the undriven bits, then SAMPLE.
  - Required response: 0x3A5 & ~0x255 | 0x255 = 0x3F5.
  - `rsp_valid` held while `rsp_ready` = 0 for 3 cycles, with `rsp_data` stable throughout.
- WAIT 5: `cmd_ready` low for exactly 5 cycles. A command presented during the wait is not consumed. WAIT 0 does not drop `cmd_ready`.
- Sync latency with the macro defined: the pad model changes 0x000 → 0x244, then SAMPLE is issued 1 cycle later and again 2 cycles later.
  - Required responses: 0x000, then 0x244.
  - Without the macro, a SAMPLE issued 1 cycle later returns 0x244.
- Reset mid-WAIT and mid-RESP: `rst_n` low for 1 cycle drops `rsp_valid`, clears direction to 0x000, and restores `cmd_ready` to 1 on the following cycle.
